// File: rtl/y_huff_bit_reader_if.sv
// Bitstream reader bus: word input, peek/consume window, status.
// stuff_cnt exists only when BYTE_UNSTUFF_EN is defined.
interface y_huff_bit_reader_if #(
    parameter int WORD_W = 32,
    parameter int PEEK_W = 16
);
    logic [WORD_W-1:0] in_data;
    logic [5:0]        in_bits;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [PEEK_W-1:0] peek;
    logic [6:0]        avail;
    logic              consume_en;
    logic [4:0]        consume_n;
    logic              underflow;
`ifdef BYTE_UNSTUFF_EN
    logic [15:0]       stuff_cnt;

    modport master (output in_data, in_bits, in_valid, flush, consume_en, consume_n,
                    input  in_ready, peek, avail, underflow, stuff_cnt);
    modport slave  (input  in_data, in_bits, in_valid, flush, consume_en, consume_n,
                    output in_ready, peek, avail, underflow, stuff_cnt);
`else
    modport master (output in_data, in_bits, in_valid, flush, consume_en, consume_n,
                    input  in_ready, peek, avail, underflow);
    modport slave  (input  in_data, in_bits, in_valid, flush, consume_en, consume_n,
                    output in_ready, peek, avail, underflow);
`endif
endinterface

// File: rtl/y_huff_bit_reader.sv
// MSB-first bit reader feeding the Y Huffman decoder: 64-bit buffer, 16-bit peek, variable consume.
// Optional BYTE_UNSTUFF_EN removes JPEG 0x00 stuffing bytes that follow 0xFF.
`ifdef BYTE_UNSTUFF_EN
module y_huff_unstuff_lane (
    input  logic [7:0] byt,
    input  logic       prev_ff,
    input  logic       en,
    output logic       is_ff,
    output logic       rm
);
    assign is_ff = (byt == 8'hFF);
    assign rm    = en && prev_ff && (byt == 8'h00);
endmodule
`endif

module y_huff_bit_reader #(
    parameter int WORD_W = 32,
    parameter int PEEK_W = 16,
    parameter int BUF_W  = 64
) (
    input logic              clk,
    input logic              rst,
    y_huff_bit_reader_if.slave bus
);
    localparam int NBYTES = WORD_W / 8;

    logic [BUF_W-1:0]  bit_buf;
    logic [6:0]        cnt;
    logic              underflow_q;

    assign bus.peek      = bit_buf[BUF_W-1 -: PEEK_W];
    assign bus.avail     = cnt;
    assign bus.underflow = underflow_q;
    assign bus.in_ready  = (cnt <= 7'(BUF_W - WORD_W)) && !bus.flush;

    logic [5:0]        k_raw;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] app_word;
    logic [5:0]        app_k;
    logic              acc;

    assign k_raw   = (bus.in_bits > 6'(WORD_W)) ? 6'(WORD_W) : bus.in_bits;
    assign in_word = bus.in_data & ~({WORD_W{1'b1}} >> k_raw);
    assign acc     = bus.in_valid && bus.in_ready;

`ifdef BYTE_UNSTUFF_EN
    logic                   last_ff;
    logic                   last_ff_nxt;
    logic [15:0]            stuff_cnt;
    logic [2:0]             nb;
    logic [2:0]             rm_cnt;
    logic [2:0]             kept;
    logic [NBYTES-1:0][7:0] bytes;
    logic [NBYTES-1:0]      is_ff, rm, prev_ff;

    assign nb            = k_raw[5:3];
    assign bus.stuff_cnt = stuff_cnt;

    // Lane 0 is the oldest byte; its predecessor is the last byte of the previous word.
    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        assign bytes[g] = in_word[WORD_W-1-8*g -: 8];
        if (g == 0) begin : g_first
            assign prev_ff[g] = last_ff;
        end else begin : g_rest
            assign prev_ff[g] = is_ff[g-1];
        end
        y_huff_unstuff_lane u_lane (
            .byt    (bytes[g]),
            .prev_ff(prev_ff[g]),
            .en     (nb > 3'(g)),
            .is_ff  (is_ff[g]),
            .rm     (rm[g])
        );
    end

    always_comb begin
        app_word    = '0;
        kept        = 3'd0;
        rm_cnt      = 3'd0;
        last_ff_nxt = last_ff;
        for (int i = 0; i < NBYTES; i++) begin
            if (3'(i) < nb) begin
                last_ff_nxt = is_ff[i];
                if (rm[i]) begin
                    rm_cnt = rm_cnt + 3'd1;
                end else begin
                    app_word = app_word | ({bytes[i], {(WORD_W-8){1'b0}}} >> {kept, 3'b000});
                    kept     = kept + 3'd1;
                end
            end
        end
        app_k = {kept, 3'b000};
    end
`else
    assign app_word = in_word;
    assign app_k    = k_raw;
`endif

    logic             legal;
    logic [6:0]       cons;
    logic [6:0]       base;
    logic [BUF_W-1:0] nxt_buf;
    logic [6:0]       nxt_cnt;

    // Consume lands first; the appended word then starts at the post-consume tail.
    assign legal   = bus.consume_en && (bus.consume_n <= 5'(PEEK_W)) && ({2'b00, bus.consume_n} <= cnt);
    assign cons    = legal ? {2'b00, bus.consume_n} : 7'd0;
    assign base    = cnt - cons;
    assign nxt_buf = (bit_buf << cons) |
                     (acc ? ({app_word, {(BUF_W-WORD_W){1'b0}}} >> base) : {BUF_W{1'b0}});
    assign nxt_cnt = base + (acc ? {1'b0, app_k} : 7'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_buf     <= '0;
            cnt         <= '0;
            underflow_q <= 1'b0;
`ifdef BYTE_UNSTUFF_EN
            last_ff     <= 1'b0;
            stuff_cnt   <= '0;
`endif
        end else if (bus.flush) begin
            bit_buf     <= '0;
            cnt         <= '0;
            underflow_q <= 1'b0;
`ifdef BYTE_UNSTUFF_EN
            last_ff     <= 1'b0;
            stuff_cnt   <= '0;
`endif
        end else begin
            bit_buf <= nxt_buf;
            cnt     <= nxt_cnt;
            if (bus.consume_en && !legal) underflow_q <= 1'b1;
`ifdef BYTE_UNSTUFF_EN
            if (acc) begin
                last_ff   <= last_ff_nxt;
                stuff_cnt <= stuff_cnt + 16'(rm_cnt);
            end
`endif
        end
    end
endmodule

// File: tb/tb_y_huff_bit_reader.sv
// Directed bench for y_huff_bit_reader: append, consume, full/empty boundaries, flush, reset.
module tb_y_huff_bit_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    y_huff_bit_reader_if #(.WORD_W(32), .PEEK_W(16)) bus ();

    y_huff_bit_reader #(.WORD_W(32), .PEEK_W(16), .BUF_W(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.in_data    = '0;
        bus.in_bits    = '0;
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.consume_en = 1'b0;
        bus.consume_n  = '0;
    endtask

    // Apply the current inputs for one edge, then return inputs to idle 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic [31:0] w, input logic [5:0] b);
        bus.in_data = w; bus.in_bits = b; bus.in_valid = 1'b1;
        cyc();
    endtask

    task automatic consume(input logic [4:0] n);
        bus.consume_en = 1'b1; bus.consume_n = n;
        cyc();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.avail !== 7'd0) begin errs++; $display("FAIL reset_avail: got %0d want 0", bus.avail); end
        checks++; if (bus.peek !== 16'h0000) begin errs++; $display("FAIL reset_peek: got %h want 0000", bus.peek); end
        checks++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL reset_underflow: got %b want 0", bus.underflow); end
    endtask

    task automatic test_append();
        push(32'hA500_0000, 6'd8);
        checks++; if (bus.peek !== 16'hA500) begin errs++; $display("FAIL append1_peek: got %h want A500", bus.peek); end
        push(32'h3C00_0000, 6'd8);
        checks++; if (bus.avail !== 7'd16) begin errs++; $display("FAIL append2_avail: got %0d want 16", bus.avail); end
        checks++; if (bus.peek !== 16'hA53C) begin errs++; $display("FAIL append2_peek: got %h want A53C", bus.peek); end
        push(32'hFFFF_FFFF, 6'd0);
        checks++; if (bus.avail !== 7'd16 || bus.peek !== 16'hA53C) begin errs++; $display("FAIL append_zero_bits: got %0d/%h want 16/A53C", bus.avail, bus.peek); end
        do_flush();
        // Only the top 4 bits of an all-ones word may land; the rest must stay zero.
        push(32'hFFFF_FFFF, 6'd4);
        checks++; if (bus.avail !== 7'd4 || bus.peek !== 16'hF000) begin errs++; $display("FAIL append_mask: got %0d/%h want 4/F000", bus.avail, bus.peek); end
        do_flush();
        push(32'hDEAD_BEEF, 6'd40);
        checks++; if (bus.avail !== 7'd32 || bus.peek !== 16'hDEAD) begin errs++; $display("FAIL append_clamp: got %0d/%h want 32/DEAD", bus.avail, bus.peek); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        push(32'hFFFF_FFFF, 6'd32);
        push(32'h1234_5678, 6'd32);
        checks++; if (bus.avail !== 7'd64) begin errs++; $display("FAIL full_avail: got %0d want 64", bus.avail); end
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
        consume(5'd16);
        checks++; if (bus.peek !== 16'hFFFF || bus.avail !== 7'd48) begin errs++; $display("FAIL full_c1: got %h/%0d want FFFF/48", bus.peek, bus.avail); end
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL full_c1_ready: got %b want 0", bus.in_ready); end
        consume(5'd16);
        checks++; if (bus.peek !== 16'h1234 || bus.avail !== 7'd32) begin errs++; $display("FAIL full_c2: got %h/%0d want 1234/32", bus.peek, bus.avail); end
        checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL full_c2_ready: got %b want 1", bus.in_ready); end
        push(32'h8000_0000, 6'd1);
        checks++; if (bus.avail !== 7'd33 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL full33: got %0d/%b want 33/0", bus.avail, bus.in_ready); end
        push(32'hAAAA_AAAA, 6'd8);
        checks++; if (bus.avail !== 7'd33 || bus.peek !== 16'h1234) begin errs++; $display("FAIL full_reject: got %0d/%h want 33/1234", bus.avail, bus.peek); end
        do_flush();
    endtask

    task automatic test_underflow();
        push(32'hA500_0000, 6'd8);
        consume(5'd12);
        checks++; if (bus.avail !== 7'd8 || bus.peek !== 16'hA500) begin errs++; $display("FAIL uf_unchanged: got %0d/%h want 8/A500", bus.avail, bus.peek); end
        checks++; if (bus.underflow !== 1'b1) begin errs++; $display("FAIL uf_flag: got %b want 1", bus.underflow); end
        consume(5'd0);
        checks++; if (bus.underflow !== 1'b1) begin errs++; $display("FAIL uf_sticky: got %b want 1", bus.underflow); end
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hFFFF_FFFF; bus.in_bits = 6'd32;
        bus.consume_en = 1'b1; bus.consume_n = 5'd4;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
        cyc();
        checks++; if (bus.avail !== 7'd0 || bus.peek !== 16'h0000) begin errs++; $display("FAIL flush_state: got %0d/%h want 0/0000", bus.avail, bus.peek); end
        checks++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL flush_uf: got %b want 0", bus.underflow); end
        consume(5'd0);
        checks++; if (bus.underflow !== 1'b0 || bus.avail !== 7'd0) begin errs++; $display("FAIL empty_c0: got %b/%0d want 0/0", bus.underflow, bus.avail); end
        push(32'hFFFF_FFFF, 6'd32);
        consume(5'd17);
        checks++; if (bus.underflow !== 1'b1 || bus.avail !== 7'd32) begin errs++; $display("FAIL uf_n17: got %b/%0d want 1/32", bus.underflow, bus.avail); end
        do_flush();
    endtask

    task automatic test_simultaneous();
        push(32'hABCD_E000, 6'd20);
        checks++; if (bus.avail !== 7'd20 || bus.peek !== 16'hABCD) begin errs++; $display("FAIL sim_setup: got %0d/%h want 20/ABCD", bus.avail, bus.peek); end
        bus.in_data = 32'h8000_0000; bus.in_bits = 6'd1; bus.in_valid = 1'b1;
        bus.consume_en = 1'b1; bus.consume_n = 5'd4;
        cyc();
        checks++; if (bus.avail !== 7'd17 || bus.peek !== 16'hBCDE) begin errs++; $display("FAIL sim_legal: got %0d/%h want 17/BCDE", bus.avail, bus.peek); end
        consume(5'd16);
        checks++; if (bus.avail !== 7'd1 || bus.peek !== 16'h8000) begin errs++; $display("FAIL sim_tail: got %0d/%h want 1/8000", bus.avail, bus.peek); end
        bus.in_data = 32'hC000_0000; bus.in_bits = 6'd2; bus.in_valid = 1'b1;
        bus.consume_en = 1'b1; bus.consume_n = 5'd5;
        cyc();
        checks++; if (bus.avail !== 7'd3 || bus.peek !== 16'hE000 || bus.underflow !== 1'b1) begin
            errs++; $display("FAIL sim_illegal: got %0d/%h/%b want 3/E000/1", bus.avail, bus.peek, bus.underflow); end
        do_flush();
    endtask

    task automatic test_async_reset();
        push(32'h1234_5678, 6'd32);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.avail !== 7'd0 || bus.peek !== 16'h0000) begin errs++; $display("FAIL async_rst: got %0d/%h want 0/0000", bus.avail, bus.peek); end
        #1 rst = 1'b0;
    endtask

`ifdef BYTE_UNSTUFF_EN
    task automatic test_unstuff();
        push(32'hFF00_AB00, 6'd32);
        checks++; if (bus.avail !== 7'd24 || bus.peek !== 16'hFFAB) begin errs++; $display("FAIL us_word: got %0d/%h want 24/FFAB", bus.avail, bus.peek); end
        checks++; if (bus.stuff_cnt !== 16'd1) begin errs++; $display("FAIL us_cnt1: got %0d want 1", bus.stuff_cnt); end
        consume(5'd16);
        push(32'h12FF_0000, 6'd16);
        consume(5'd16);
        push(32'h0034_0000, 6'd16);
        checks++; if (bus.avail !== 7'd16 || bus.peek !== 16'hFF34) begin errs++; $display("FAIL us_cross: got %0d/%h want 16/FF34", bus.avail, bus.peek); end
        checks++; if (bus.stuff_cnt !== 16'd2) begin errs++; $display("FAIL us_cnt2: got %0d want 2", bus.stuff_cnt); end
        do_flush();
        checks++; if (bus.stuff_cnt !== 16'd0) begin errs++; $display("FAIL us_flush: got %0d want 0", bus.stuff_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_append();
        test_back_to_back();
        test_underflow();
        test_simultaneous();
`ifdef BYTE_UNSTUFF_EN
        test_unstuff();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
